// File: rtl/wavelet_input_sampler.sv
// wavelet_input_sampler: synchronizes an external strobe/data bus and buffers samples in a show-ahead FIFO.
module wavelet_input_sampler #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          i_data_clk,
  input  logic [DATA_W-1:0]             i_value,
  output logic [DATA_W-1:0]             o_sample,
  output logic                          o_sample_valid,
  input  logic                          i_sample_ready,
  output logic                          o_overflow,
  input  logic                          i_clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [CNT_W-1:0]              o_sample_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic {DISARMED, ARMED} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] strobe_sync, settle;
  logic [DATA_W-1:0] value_sync [SYNC_STAGES];
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic strobe_prev, push, pop, full, accept;
  logic [AW:0] wr_ptr, rd_ptr;
  assign push = (state == ARMED) && strobe_sync[SYNC_STAGES-1] && !strobe_prev;
  assign o_fifo_level = wr_ptr - rd_ptr;
  assign o_sample_valid = wr_ptr != rd_ptr;
  assign full = o_fifo_level == LW'(FIFO_DEPTH);
  assign pop = o_sample_valid && i_sample_ready;
  assign accept = push && (!full || pop);
  assign o_sample = o_sample_valid ? mem[rd_ptr[AW-1:0]] : '0;
  // settle marks when the chain holds real pin samples rather than reset zeros,
  // so a pin held high through reset cannot arm and then fire a false edge
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      strobe_sync <= '0;
      settle <= '0;
      strobe_prev <= 1'b0;
      state <= DISARMED;
      for (int i = 0; i < SYNC_STAGES; i++) value_sync[i] <= '0;
    end else begin
      strobe_sync <= {strobe_sync[SYNC_STAGES-2:0], i_data_clk};
      settle <= {settle[SYNC_STAGES-2:0], 1'b1};
      strobe_prev <= strobe_sync[SYNC_STAGES-1];
      value_sync[0] <= i_value;
      for (int i = 1; i < SYNC_STAGES; i++) value_sync[i] <= value_sync[i-1];
      if (state == DISARMED && settle[SYNC_STAGES-1] && !strobe_sync[SYNC_STAGES-1]) state <= ARMED;
    end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_overflow <= 1'b0;
      o_sample_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept) o_sample_count <= o_sample_count + 1'b1;
      if (push && full && !pop) o_overflow <= 1'b1;
      else if (i_clear_overflow) o_overflow <= 1'b0;
    end
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr[AW-1:0]] <= value_sync[SYNC_STAGES-1];
endmodule

// File: tb/tb_wavelet_input_sampler.sv
// tb_wavelet_input_sampler: directed checks of capture latency, FIFO, overflow, arming and count wrap.
module tb_wavelet_input_sampler;
  logic clk = 1'b0, resetb, i_data_clk, i_sample_ready, i_clear_overflow;
  logic [7:0] i_value, o_sample, o2_sample;
  logic o_sample_valid, o_overflow, o2_sample_valid, o2_overflow;
  logic [2:0] o_fifo_level, o2_fifo_level;
  logic [15:0] o_sample_count;
  logic [3:0] o2_sample_count;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  wavelet_input_sampler dut (
    .clk(clk), .resetb(resetb), .i_data_clk(i_data_clk), .i_value(i_value),
    .o_sample(o_sample), .o_sample_valid(o_sample_valid), .i_sample_ready(i_sample_ready),
    .o_overflow(o_overflow), .i_clear_overflow(i_clear_overflow),
    .o_fifo_level(o_fifo_level), .o_sample_count(o_sample_count)
  );
  wavelet_input_sampler #(.CNT_W(4)) dut_w (
    .clk(clk), .resetb(resetb), .i_data_clk(i_data_clk), .i_value(i_value),
    .o_sample(o2_sample), .o_sample_valid(o2_sample_valid), .i_sample_ready(1'b1),
    .o_overflow(o2_overflow), .i_clear_overflow(1'b0),
    .o_fifo_level(o2_fifo_level), .o_sample_count(o2_sample_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset(input logic hi);
    @(negedge clk);
    resetb = 1'b0;
    i_data_clk = hi;
    i_sample_ready = 1'b0;
    i_clear_overflow = 1'b0;
    i_value = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_valid", o_sample_valid, 0);
    check("rst_level", o_fifo_level, 0);
    check("rst_sample", o_sample, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_count", o_sample_count, 0);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  // pulse bit0 = ready, bit1 = clear, asserted on the cycle the push lands
  task automatic send(input logic [7:0] v, input logic [1:0] pulse);
    @(negedge clk) i_value = v;
    @(negedge clk) i_data_clk = 1'b1;
    repeat (2) @(negedge clk);
    if (pulse[0]) i_sample_ready = 1'b1;
    if (pulse[1]) i_clear_overflow = 1'b1;
    @(negedge clk);
    if (pulse[0]) i_sample_ready = 1'b0;
    if (pulse[1]) i_clear_overflow = 1'b0;
    repeat (2) @(negedge clk);
    i_data_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask
  task automatic drain(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      check("drain_head", o_sample, first + 8'(i));
      i_sample_ready = 1'b1;
      @(negedge clk) i_sample_ready = 1'b0;
    end
    check("drain_empty", o_sample_valid, 0);
  endtask
  initial begin
    resetb = 1'b0;
    do_reset(1'b0);
    i_value = 8'hA5;
    @(negedge clk) i_data_clk = 1'b1;
    @(negedge clk) check("lat_e1", o_sample_valid, 0);
    @(negedge clk) check("lat_e2", o_sample_valid, 0);
    @(negedge clk) check("lat_e3", o_sample_valid, 1);
    check("first_sample", o_sample, 8'hA5);
    check("first_count", o_sample_count, 1);
    check("first_level", o_fifo_level, 1);
    @(negedge clk) i_sample_ready = 1'b1;
    @(negedge clk) begin
      i_sample_ready = 1'b0;
      i_data_clk = 1'b0;
    end
    check("pop_level", o_fifo_level, 0);
    check("pop_valid", o_sample_valid, 0);
    check("pop_sample", o_sample, 0);
    repeat (5) @(negedge clk);
    do_reset(1'b0);
    for (int v = 1; v <= 5; v++) send(8'(v), 2'b00);
    check("ovf_level", o_fifo_level, 4);
    check("ovf_count", o_sample_count, 4);
    check("ovf_flag", o_overflow, 1);
    check("ovf_head", o_sample, 8'h01);
    drain(8'h01, 4);
    do_reset(1'b0);
    for (int v = 1; v <= 4; v++) send(8'(v), 2'b00);
    send(8'h05, 2'b01);
    check("fullpop_level", o_fifo_level, 4);
    check("fullpop_count", o_sample_count, 5);
    check("fullpop_ovf", o_overflow, 0);
    drain(8'h02, 4);
    do_reset(1'b0);
    for (int v = 1; v <= 5; v++) send(8'(v), 2'b00);
    check("clr_pre", o_overflow, 1);
    send(8'h06, 2'b10);
    check("clr_setwins", o_overflow, 1);
    check("clr_level", o_fifo_level, 4);
    check("clr_head", o_sample, 8'h01);
    check("clr_count", o_sample_count, 4);
    i_clear_overflow = 1'b1;
    @(negedge clk) i_clear_overflow = 1'b0;
    check("clr_alone", o_overflow, 0);
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    check("hold_valid", o_sample_valid, 0);
    check("hold_count", o_sample_count, 0);
    i_value = 8'h3C;
    i_data_clk = 1'b0;
    repeat (3) @(negedge clk);
    i_data_clk = 1'b1;
    repeat (5) @(negedge clk);
    i_data_clk = 1'b0;
    repeat (5) @(negedge clk);
    check("arm_count", o_sample_count, 1);
    check("arm_level", o_fifo_level, 1);
    check("arm_head", o_sample, 8'h3C);
    do_reset(1'b0);
    i_sample_ready = 1'b1;
    for (int v = 1; v <= 15; v++) send(8'(v), 2'b00);
    check("wrap_pre", o2_sample_count, 4'hF);
    check("wrap_level", o_fifo_level, 0);
    send(8'h10, 2'b00);
    check("wrap_zero", o2_sample_count, 4'h0);
    check("wrap_wide", o_sample_count, 16);
    i_sample_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wavelet_input_sampler.md
Name: wavelet_input_sampler

Overview:
- Upstream front-end for the wavelet transform core. Captures 8-bit samples from GPIO pins i_value, strobed by the external asynchronous i_data_clk pin.
- Synchronizes the strobe into the system clock domain and detects its rising edges.
- Buffers the captured samples in a small show-ahead FIFO and presents them to the core over a valid/ready handshake.
- Also reports overflow, FIFO level and a count of accepted samples for logic-analyser readback.

Parameters:
DATA_W, 8, sample width (matches i_value)
FIFO_DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, synchronizer flops on i_data_clk and on the i_value path; >=2
CNT_W, 16, width of accepted-sample counter

Ports:
clk  input  1  system clock
resetb  input  1  asynchronous active-low reset
i_data_clk  input  1  external sample strobe, asynchronous to clk; sample on its rising edge
i_value  input  DATA_W  external sample data
o_sample  output  DATA_W  FIFO head; 0 when FIFO empty
o_sample_valid  output  1  FIFO non-empty
i_sample_ready  input  1  core accepts head this cycle
o_overflow  output  1  sticky: a sample was dropped
i_clear_overflow  input  1  clears o_overflow
o_fifo_level  output  $clog2(FIFO_DEPTH)+1  occupied entries
o_sample_count  output  CNT_W  samples accepted into the FIFO, wraps

Behaviour:
- Reset (resetb low, async): sync chains, edge register, FIFO pointers, armed flag, overflow and count all go to 0.
  - Outputs during reset: o_sample=0, o_sample_valid=0, o_overflow=0, o_fifo_level=0, o_sample_count=0.
  - Reset mid-operation discards all buffered samples.
- Synchronizer:
  - i_data_clk passes through SYNC_STAGES flops.
  - i_value passes through a parallel SYNC_STAGES-deep register pipeline, so data and strobe stay aligned.
  - Input contract: i_value must be stable from 1 clk before until SYNC_STAGES+1 clks after the i_data_clk rising edge.
  - i_data_clk high and low phases must each be >= SYNC_STAGES+1 clks.
- Arming state machine, states DISARMED and ARMED:
  - DISARMED is the reset state. Move to ARMED when the synchronized strobe is observed low.
  - Edges are ignored while DISARMED. This prevents a spurious sample when the pin is held high through reset release.
  - ARMED remains until reset.
- Edge detect: push = ARMED & sync_strobe & ~sync_strobe_prev.
- Latency: with the FIFO empty, o_sample_valid rises exactly SYNC_STAGES+1 clk edges after the first clk edge that samples i_data_clk high.
- FIFO behaviour:
  - Show-ahead: o_sample = mem[rd_ptr] whenever o_sample_valid.
  - pop = o_sample_valid & i_sample_ready. A pop while empty is ignored.
  - Push while not full: write, and increment o_sample_count (mod 2^CNT_W).
  - Push while full with no pop in the same cycle: sample dropped, o_overflow set, count unchanged.
  - Push while full with a pop in the same cycle: accepted, level stays FIFO_DEPTH, count increments.
  - Push while empty: data becomes visible on o_sample the next cycle (no same-cycle bypass).
- Level and pointers:
  - o_fifo_level = wr_ptr - rd_ptr, using pointers one bit wider than the address.
  - Both pointers wrap naturally.
- Overflow flag:
  - i_clear_overflow clears o_overflow on the next edge.
  - If a set event and a clear occur in the same cycle, set wins.
- All outputs are registered or derived directly from registers. No combinational path from i_sample_ready to o_sample_valid.

Test Plan:
- Reset, then i_data_clk low 5 clks, then high 5 clks with i_value=0xA5 -> o_sample_valid rises 3 edges after the strobe is sampled high; o_sample=0xA5; count=1; level=1; ready=1 pops it and level returns to 0.
- i_sample_ready=0; 5 strobes with values 0x01..0x05 -> level=4, count=4, o_overflow=1, head=0x01; draining yields 0x01..0x04 in order (0x05 lost).
- FIFO full, ready held 1 while the 5th strobe (0x05) arrives on the pop cycle -> 0x05 accepted, level stays 4, count=5, o_overflow stays 0.
- i_data_clk held high across reset release, then held high 10 clks -> no sample. Then low 3 clks and high again -> exactly one sample captured.
- Force count to 0xFFFF via 65535 strobes (or a backdoor preload), one more strobe -> o_sample_count=0x0000.
- o_overflow=1 and i_clear_overflow pulsed in the same cycle as a dropped push -> o_overflow stays 1. Clear alone on a later cycle -> 0 next edge.
